// File: rtl/reg_cut_timeout.sv
// -----------------------------------------------------------------------------
// reg_cut_timeout
//
// Single-entry register slice for the register bus. It sits between the
// APB-to-register-bus bridge and the peripheral register files. The request
// payload and the response are both registered, which breaks the
// combinational ready/rdata path back to APB. A watchdog ends any access the
// target leaves pending for TIMEOUT_CYCLES cycles and answers it with an
// error, so the APB master can never hang.
//
// Parameters:
//   ADDR_WIDTH      register-bus address width
//   DATA_WIDTH      register-bus data width (strobes are DATA_WIDTH/8 wide)
//   TIMEOUT_CYCLES  cycles m_valid_o may stay high without m_ready_i;
//                   0 disables the watchdog
//
// Ports:
//   clk_i, rst_ni               clock, asynchronous active-low reset
//   s_addr_i .. s_valid_i       upstream request (held stable until s_ready_o)
//   s_rdata_o, s_ready_o,       upstream response: one-cycle ready pulse with
//   s_error_o                   rdata/error valid in that cycle
//   m_addr_o .. m_valid_o       downstream request, payload registered
//   m_rdata_i, m_ready_i,       downstream completion
//   m_error_i
//   timeout_o                   one-cycle pulse, coincident with the error
//                               response produced by the watchdog
//   timeout_cnt_o               saturating count of watchdog expiries
//
// Optional feature macro: REG_CUT_TIMEOUT_CNT_EN
//   defined   -> 16-bit saturating counter of timeout_o pulses on timeout_cnt_o
//   undefined -> timeout_cnt_o is tied to 0, no counter flops
// -----------------------------------------------------------------------------
module reg_cut_timeout #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,

    input  logic [ADDR_WIDTH-1:0]   s_addr_i,
    input  logic                    s_write_i,
    input  logic [DATA_WIDTH-1:0]   s_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] s_wstrb_i,
    input  logic                    s_valid_i,
    output logic [DATA_WIDTH-1:0]   s_rdata_o,
    output logic                    s_ready_o,
    output logic                    s_error_o,

    output logic [ADDR_WIDTH-1:0]   m_addr_o,
    output logic                    m_write_o,
    output logic [DATA_WIDTH-1:0]   m_wdata_o,
    output logic [DATA_WIDTH/8-1:0] m_wstrb_o,
    output logic                    m_valid_o,
    input  logic [DATA_WIDTH-1:0]   m_rdata_i,
    input  logic                    m_ready_i,
    input  logic                    m_error_i,

    output logic                    timeout_o,
    output logic [15:0]             timeout_cnt_o
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam bit WDOG_EN    = (TIMEOUT_CYCLES > 0);
    localparam int CNT_W      = WDOG_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    // Counter value in the last permitted REQ cycle (the N-th valid cycle).
    localparam logic [CNT_W-1:0] CNT_LAST =
        WDOG_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    write_q, write_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    error_q, error_d;
    logic                    timeout_q, timeout_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rdata_d   = rdata_q;
        error_d   = error_q;
        timeout_d = 1'b0;
        cnt_d     = cnt_q;

        case (state_q)
            IDLE: begin
                if (s_valid_i) begin
                    addr_d  = s_addr_i;
                    write_d = s_write_i;
                    wdata_d = s_wdata_i;
                    wstrb_d = s_wstrb_i;
                    cnt_d   = '0;
                    state_d = REQ;
                end
            end

            REQ: begin
                // A ready arriving in the expiry cycle takes priority over
                // the watchdog.
                if (m_ready_i) begin
                    rdata_d = write_q ? '0 : m_rdata_i;
                    error_d = m_error_i;
                    state_d = RSP;
                end else if (WDOG_EN) begin
                    if (cnt_q == CNT_LAST) begin
                        rdata_d   = '0;
                        error_d   = 1'b1;
                        timeout_d = 1'b1;
                        state_d   = RSP;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            RSP: begin
                // Response is visible for this single cycle only.
                rdata_d = '0;
                error_d = 1'b0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            error_q   <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
            error_q   <= error_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
        end
    end

    assign m_addr_o  = addr_q;
    assign m_write_o = write_q;
    assign m_wdata_o = wdata_q;
    assign m_wstrb_o = wstrb_q;
    assign m_valid_o = (state_q == REQ);

    assign s_rdata_o = rdata_q;
    assign s_error_o = error_q;
    assign s_ready_o = (state_q == RSP);
    assign timeout_o = timeout_q;

`ifdef REG_CUT_TIMEOUT_CNT_EN
    logic [15:0] tcnt_q, tcnt_d;

    always_comb begin
        tcnt_d = tcnt_q;
        if (timeout_q && (tcnt_q != 16'hFFFF)) begin
            tcnt_d = tcnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tcnt_q <= 16'd0;
        end else begin
            tcnt_q <= tcnt_d;
        end
    end

    assign timeout_cnt_o = tcnt_q;
`else
    assign timeout_cnt_o = 16'd0;
`endif

endmodule

// File: tb/tb_reg_cut_timeout.sv
module tb_reg_cut_timeout;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int N  = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] s_addr;
    logic          s_write;
    logic [DW-1:0] s_wdata;
    logic [SW-1:0] s_wstrb;
    logic          s_valid;
    logic [DW-1:0] s_rdata_o;
    logic          s_ready_o;
    logic          s_error_o;
    logic [AW-1:0] m_addr_o;
    logic          m_write_o;
    logic [DW-1:0] m_wdata_o;
    logic [SW-1:0] m_wstrb_o;
    logic          m_valid_o;
    logic [DW-1:0] m_rdata;
    logic          m_ready;
    logic          m_error;
    logic          timeout_o;
    logic [15:0]   timeout_cnt_o;

    int total = 0;
    int bad   = 0;
    int n_to  = 0;

    always #5 clk = ~clk;

    reg_cut_timeout #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(N)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .s_addr_i     (s_addr),
        .s_write_i    (s_write),
        .s_wdata_i    (s_wdata),
        .s_wstrb_i    (s_wstrb),
        .s_valid_i    (s_valid),
        .s_rdata_o    (s_rdata_o),
        .s_ready_o    (s_ready_o),
        .s_error_o    (s_error_o),
        .m_addr_o     (m_addr_o),
        .m_write_o    (m_write_o),
        .m_wdata_o    (m_wdata_o),
        .m_wstrb_o    (m_wstrb_o),
        .m_valid_o    (m_valid_o),
        .m_rdata_i    (m_rdata),
        .m_ready_i    (m_ready),
        .m_error_i    (m_error),
        .timeout_o    (timeout_o),
        .timeout_cnt_o(timeout_cnt_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_tcnt();
`ifdef REG_CUT_TIMEOUT_CNT_EN
        return (n_to > 65535) ? 16'hFFFF : 16'(n_to);
`else
        return 16'd0;
`endif
    endfunction

    // One complete access. 'stall' is the number of valid cycles without
    // ready before the target answers (ready on valid cycle stall+1).
    // Called right after a falling edge; returns right after a falling edge
    // with the DUT idle, so consecutive calls are back-to-back.
    task automatic run_txn(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] wd,
                           input logic [SW-1:0] ws, input logic [DW-1:0] rd,
                           input logic me, input int stall);
        int            exp_vcyc;
        bit            exp_to;
        logic [DW-1:0] exp_rdata;
        logic          exp_err;
        int            vcyc;
        bit            done;

        // Reference: the target answers at stall+1 unless the watchdog
        // (N valid cycles) runs out first.
        if (stall + 1 > N) begin
            exp_vcyc  = N;
            exp_to    = 1'b1;
            exp_rdata = '0;
            exp_err   = 1'b1;
        end else begin
            exp_vcyc  = stall + 1;
            exp_to    = 1'b0;
            exp_rdata = w ? '0 : rd;
            exp_err   = me;
        end

        s_valid = 1'b1;
        s_addr  = a;
        s_write = w;
        s_wdata = wd;
        s_wstrb = ws;
        m_ready = 1'b0;
        m_rdata = $urandom;
        m_error = 1'b0;
        vcyc    = 0;
        done    = 1'b0;

        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge clk);
            if (c == 0) check("accept_latency", 64'(m_valid_o), 64'd1);
            if (m_valid_o) begin
                vcyc++;
                check("m_addr", 64'(m_addr_o), 64'(a));
                check("m_write", 64'(m_write_o), 64'(w));
                check("m_wdata", 64'(m_wdata_o), 64'(wd));
                check("m_wstrb", 64'(m_wstrb_o), 64'(ws));
                check("s_ready_in_req", 64'(s_ready_o), 64'd0);
                // Upstream payload changes must not reach the held request.
                s_addr  = $urandom;
                s_write = 1'($urandom);
                s_wdata = $urandom;
                s_wstrb = SW'($urandom);
                if (vcyc == stall + 1) begin
                    m_ready = 1'b1;
                    m_rdata = rd;
                    m_error = me;
                end else begin
                    m_ready = 1'b0;
                    m_rdata = $urandom;
                    m_error = 1'($urandom);
                end
            end else if (s_ready_o) begin
                check("valid_cycles", 64'(vcyc), 64'(exp_vcyc));
                check("s_rdata", 64'(s_rdata_o), 64'(exp_rdata));
                check("s_error", 64'(s_error_o), 64'(exp_err));
                check("timeout_pulse", 64'(timeout_o), 64'(exp_to));
                // s_valid stays high through the response cycle and m_ready
                // is random: both must be ignored there.
                m_ready = 1'($urandom);
                m_rdata = $urandom;
                m_error = 1'($urandom);
                done    = 1'b1;
            end else begin
                check("handshake_state", 64'({m_valid_o, s_ready_o}), 64'd2);
                done = 1'b1;
            end
        end
        check("txn_bound", 64'(done), 64'd1);

        @(negedge clk);
        if (exp_to) n_to++;
        check("ready_single_pulse", 64'(s_ready_o), 64'd0);
        check("no_accept_in_rsp", 64'(m_valid_o), 64'd0);
        check("s_rdata_cleared", 64'(s_rdata_o), 64'd0);
        check("s_error_cleared", 64'(s_error_o), 64'd0);
        check("timeout_single_pulse", 64'(timeout_o), 64'd0);
        check("timeout_cnt", 64'(timeout_cnt_o), 64'(exp_tcnt()));
        s_valid = 1'b0;
        m_ready = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        s_addr  = '0;
        s_write = 1'b0;
        s_wdata = '0;
        s_wstrb = '0;
        s_valid = 1'b0;
        m_rdata = '0;
        m_ready = 1'b0;
        m_error = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_m_valid", 64'(m_valid_o), 64'd0);
        check("rst_s_ready", 64'(s_ready_o), 64'd0);
        check("rst_s_rdata", 64'(s_rdata_o), 64'd0);
        check("rst_s_error", 64'(s_error_o), 64'd0);
        check("rst_m_addr", 64'(m_addr_o), 64'd0);
        check("rst_m_wdata", 64'(m_wdata_o), 64'd0);
        check("rst_m_wstrb", 64'(m_wstrb_o), 64'd0);
        check("rst_m_write", 64'(m_write_o), 64'd0);
        check("rst_timeout", 64'(timeout_o), 64'd0);
        check("rst_timeout_cnt", 64'(timeout_cnt_o), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Zero-wait read.
        run_txn(32'h1000_0010, 1'b0, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, 0);
        // Write stalled for 5 valid cycles, target reports an error.
        run_txn(32'h1000_0020, 1'b1, 32'hA5A5_0001, 4'hF, 32'h5555_AAAA, 1'b1, 4);
        // Target never answers: watchdog expiry.
        run_txn(32'h1000_0030, 1'b0, 32'h0, 4'h0, 32'h0BAD_F00D, 1'b0, 1000);
        // Ready on the expiry cycle wins over the watchdog.
        run_txn(32'h1000_0040, 1'b0, 32'h0, 4'h0, 32'h0000_1234, 1'b0, N - 1);

        // Reset in the middle of a stalled request.
        s_valid = 1'b1;
        s_addr  = 32'h2000_0040;
        s_write = 1'b0;
        s_wdata = '0;
        s_wstrb = '0;
        m_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("pre_reset_valid", 64'(m_valid_o), 64'd1);
        end
        rst_n   = 1'b0;
        s_valid = 1'b0;
        #1;
        check("async_reset_valid", 64'(m_valid_o), 64'd0);
        check("async_reset_ready", 64'(s_ready_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("post_reset_ready", 64'(s_ready_o), 64'd0);
            check("post_reset_valid", 64'(m_valid_o), 64'd0);
        end
        n_to = 0;  // the 16-bit count restarts from reset
        check("post_reset_tcnt", 64'(timeout_cnt_o), 64'(exp_tcnt()));
        run_txn(32'h2000_0044, 1'b0, 32'h0, 4'h0, 32'hCAFE_0001, 1'b0, 2);

        // Back-to-back: each new request is presented in the cycle after
        // the previous ready pulse.
        run_txn(32'h3000_0000, 1'b1, 32'h1111_2222, 4'h3, 32'h0, 1'b0, 0);
        run_txn(32'h3000_0004, 1'b0, 32'h0, 4'h0, 32'h3333_4444, 1'b0, 0);

        // Randomised accesses, stalls spanning both sides of the expiry.
        for (int i = 0; i < 24; i++) begin
            run_txn($urandom, 1'($urandom), $urandom, SW'($urandom), $urandom,
                    1'($urandom), int'($urandom_range(0, 11)));
        end

        // A second expiry after the randomised mix.
        run_txn(32'h4000_0000, 1'b1, 32'hFFFF_0000, 4'hC, 32'h0, 1'b0, N);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_cut_timeout.md
Name: reg_cut_timeout

Overview:
- Single-entry register slice on the register bus, placed directly downstream of the APB-to-register-bus bridge and in front of peripheral register files.
- Registers the request path and the response path, which breaks the combinational ready/rdata loop back to APB.
- A watchdog terminates any access that the target does not complete within TIMEOUT_CYCLES, returning an error so the APB master never hangs.

Parameters:
ADDR_WIDTH, 32, register-bus address width
DATA_WIDTH, 32, register-bus data width; the strobe width is DATA_WIDTH/8
TIMEOUT_CYCLES, 256, maximum number of cycles the downstream valid stays asserted without ready; 0 disables the watchdog

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
s_addr_i  in  ADDR_WIDTH  upstream request address
s_write_i  in  1  upstream write (1) or read (0)
s_wdata_i  in  DATA_WIDTH  upstream write data
s_wstrb_i  in  DATA_WIDTH/8  upstream byte strobes
s_valid_i  in  1  upstream request valid
s_rdata_o  out  DATA_WIDTH  upstream read data, registered
s_ready_o  out  1  upstream completion, single-cycle pulse, registered
s_error_o  out  1  upstream error, valid while s_ready_o=1
m_addr_o  out  ADDR_WIDTH  downstream address, registered
m_write_o  out  1  downstream write, registered
m_wdata_o  out  DATA_WIDTH  downstream write data, registered
m_wstrb_o  out  DATA_WIDTH/8  downstream strobes, registered
m_valid_o  out  1  downstream request valid
m_rdata_i  in  DATA_WIDTH  downstream read data
m_ready_i  in  1  downstream completion
m_error_i  in  1  downstream error
timeout_o  out  1  single-cycle pulse when the watchdog fires
timeout_cnt_o  out  16  saturating timeout count (see Optional Feature)

Behaviour:
- Clocking and reset: clk_i is the only clock. rst_ni is asynchronous and active-low.
- Reset values: all outputs are 0 and the FSM is in IDLE.
- Bus rules: the master holds valid and payload stable until ready. Ready is a one-cycle completion.
- IDLE:
  - On s_valid_i=1, capture addr, write, wdata and wstrb into the m_* registers.
  - Clear the watchdog counter and go to REQ.
  - s_ready_o stays 0.
- REQ:
  - m_valid_o=1 and the payload is held constant.
  - On m_ready_i=1: latch m_rdata_i and m_error_i into the s_* registers, then go to RSP.
  - Otherwise, when TIMEOUT_CYCLES≠0, increment the counter.
  - When the counter equals TIMEOUT_CYCLES-1 and m_ready_i=0: latch rdata=0 and error=1, pulse timeout_o in the next cycle, and go to RSP.
  - m_ready_i in the same cycle as expiry: the ready wins, with no timeout and no pulse.
- RSP:
  - m_valid_o=0 and s_ready_o=1 for exactly one cycle, with s_rdata_o/s_error_o valid. Go to IDLE.
  - s_rdata_o and s_error_o return to 0 in the cycle after the pulse.
- Latency:
  - Request accepted at cycle 0 gives m_valid_o=1 at cycle 1.
  - Target ready at cycle k (k≥1) gives s_ready_o at k+1.
  - Minimum round trip is 2 cycles. The next request can be accepted at k+2.
- Timeout value: with TIMEOUT_CYCLES=N, m_valid_o is high for exactly N cycles before the error response.
- Ignored inputs:
  - s_valid_i in REQ/RSP: accepted only from IDLE.
  - m_ready_i outside REQ: no state change.
- Writes return s_rdata_o=0; rdata is latched only for reads.
- Counter width is $clog2(TIMEOUT_CYCLES+1), minimum 1.
- Reset mid-transaction: immediate return to IDLE, m_valid_o=0, no response is generated, and the counter is cleared.

Optional Feature:
- Macro: REG_CUT_TIMEOUT_CNT_EN.
- When defined: a 16-bit counter increments on each timeout_o pulse, saturates at 0xFFFF, resets to 0 and drives timeout_cnt_o.
- When undefined: timeout_cnt_o is tied to 0 and no counter flops exist. timeout_o is unaffected.

Test Plan:
- Read with a zero-wait target: s_valid_i=1, addr 0x1000_0010, m_ready_i in the first REQ cycle with rdata 0xDEAD_BEEF → m_valid_o high 1 cycle, s_ready_o at cycle 2 with s_rdata_o=0xDEAD_BEEF, s_error_o=0.
- Write with a 5-cycle stall: wdata 0xA5A5_0001, wstrb 0xF, ready after 5 cycles with m_error_i=1 → m_wdata_o stable for all 5 cycles, s_ready_o one cycle later with s_error_o=1, s_rdata_o=0.
- Timeout with TIMEOUT_CYCLES=8 and m_ready_i held 0 → m_valid_o high exactly 8 cycles, then s_ready_o=1, s_error_o=1, s_rdata_o=0 and a timeout_o pulse; with the macro defined, timeout_cnt_o=1.
- Ready on the expiry cycle (TIMEOUT_CYCLES=8, ready on the 8th valid cycle, rdata 0x1234) → s_error_o=0, s_rdata_o=0x1234, timeout_o stays 0.
- Reset mid-REQ: assert rst_ni=0 for 1 cycle after 3 stalled cycles → m_valid_o=0 immediately, no s_ready_o pulse; the next read completes normally.
- Back-to-back: a new s_valid_i presented in the cycle after s_ready_o → captured, m_valid_o asserted the following cycle with the new address.
